// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative 32-bit multiply/divide unit with HI/LO result
//               registers. MULT/MULTU use a radix-2 shift-add multiplier.
//               DIV/DIVU use a restoring divider. Both run 32 iterations.
//               MTHI/MTLO write HI/LO directly in a single cycle.
// Ports       : clk    - clock, rising edge active
//               rst_n  - synchronous active-low reset
//               a      - rs operand (multiplicand / dividend / MTHI-MTLO data)
//               b      - rt operand (multiplier / divisor)
//               op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                        100 MTHI, 101 MTLO, 11x no-op
//               start  - request; a, b and op are sampled on the same edge
//               hi, lo - HI/LO registers, always visible
//               busy   - iterative operation in progress
//               done   - one-cycle pulse when HI/LO take a mul/div result
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI   = 3'b100;
    localparam logic [2:0] OP_MTLO   = 3'b101;
    localparam logic [5:0] LAST_ITER = 6'd31;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   [31:0] holds dividend bits shifting out / quotient shifting in.
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;       // divide partial remainder
    logic [31:0] opb_q, opb_d;       // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;  // negate product / quotient
    logic        neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
    logic        dbz_q, dbz_d;          // divide by zero
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        unused_rem_msb;

    // MULT and DIV are the even encodings of the arithmetic group.
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[31]) ? (~a + 32'd1) : a;
    assign abs_b     = (signed_op && b[31]) ? (~b + 32'd1) : b;

    // Shift-add step: conditionally add the multiplicand into the upper half,
    // keeping the carry as the new MSB before the right shift.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);

    // Restoring step: bring in the next dividend bit and trial-subtract.
    // The partial remainder is always below the divisor, so 33 bits suffice
    // for the sign of the difference to be exact.
    assign div_shift = {rem_q[31:0], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix   = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    // With a zero divisor the remainder ends up equal to |a|; restoring the
    // dividend sign therefore yields the raw a for both DIV and DIVU.
    assign rem_fix   = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    // The remainder MSB is structurally always zero after a step.
    assign unused_rem_msb = rem_q[32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        // op[1] distinguishes divide from multiply.
                        is_div_d  = op[1];
                        acc_d     = {32'd0, op[1] ? abs_a : abs_b};
                        opb_d     = op[1] ? abs_b : abs_a;
                        rem_d     = 33'd0;
                        cnt_d     = 6'd0;
                        neg_res_d = signed_op & (a[31] ^ b[31]);
                        neg_rem_d = signed_op & a[31];
                        dbz_d     = (b == 32'd0);
                        state_d   = ST_CALC;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end

            ST_CALC: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div_q) begin
                    acc_d = {acc_q[63:32], acc_q[30:0], ~div_diff[32]};
                    rem_d = div_diff[32] ? div_shift : div_diff;
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (is_div_q) begin
                    lo_d = dbz_q ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            rem_q     <= 33'd0;
            opb_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. A cycle-level
//               reference model computes results with plain arithmetic and
//               is compared against the DUT every cycle; literal
//               expectations pin the model on known vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic        start;
    logic [31:0] hi, lo;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mul_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_calc(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y,
                                       output logic [31:0] rh, output logic [31:0] rl);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        rh = 32'd0;
        rl = 32'd0;
        case (o)
            3'd0: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin
                if (y == 32'd0) begin rh = x; rl = 32'hFFFF_FFFF; end
                else begin
                    q = sx / sy; r = sx % sy;
                    p = 64'(q); rl = p[31:0];
                    p = 64'(r); rh = p[31:0];
                end
            end
            3'd3: begin
                if (y == 32'd0) begin rh = x; rl = 32'hFFFF_FFFF; end
                else begin rl = x / y; rh = x % y; end
            end
            default: ;
        endcase
    endfunction

    int          m_cnt = 0;   // busy cycles remaining
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!rst_n) begin
            m_cnt = 0; m_hi = 32'd0; m_lo = 32'd0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
        end else if (start) begin
            if (op <= 3'd3) begin
                model_calc(op, a, b, p_hi, p_lo);
                m_cnt = 33;
            end else if (op == 3'd4) begin
                m_hi = a;
            end else if (op == 3'd5) begin
                m_lo = a;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_cnt != 0));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (!done && n < 40) begin
            if (busy) n++;
            @(negedge clk);
        end
        check({nm, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [2:0] o,
                          input logic [31:0] x, input logic [31:0] y);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, n);
        check({nm, "_busy_len"}, 32'(n), 32'd33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        @(negedge clk);

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFF1);
        @(negedge clk);

        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        @(negedge clk);

        run_op("divu_zero", 3'd3, 32'd100, 32'd0);
        check("divu_zero_hi", hi, 32'h0000_0064);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);
        @(negedge clk);

        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        @(negedge clk);

        run_op("div_zero", 3'd2, 32'hFFFF_FFFB, 32'd0);
        check("div_zero_hi", hi, 32'hFFFF_FFFB);
        check("div_zero_lo", lo, 32'hFFFF_FFFF);
        @(negedge clk);

        run_op("div_negdivisor", 3'd2, 32'd7, 32'hFFFF_FFFE);
        check("div_negdivisor_lo", lo, 32'hFFFF_FFFD);
        check("div_negdivisor_hi", hi, 32'd1);
        @(negedge clk);

        run_op("mult_big", 3'd0, 32'h7FFF_FFFF, 32'h8000_0000);
        @(negedge clk);
        run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd3);
        check("divu_big_lo", lo, 32'h5555_5555);
        @(negedge clk);

        // MTHI in IDLE: immediate write, LO untouched, no busy/done
        op = 3'd4; a = 32'h1234_5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo", lo, 32'h5555_5555);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_done", 32'(done), 32'd0);

        // no-op encoding
        op = 3'd6; a = 32'hDEAD_BEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nop_hi", hi, 32'h1234_5678);
        check("nop_lo", lo, 32'h5555_5555);

        // MTLO/MTHI and operand changes while busy are ignored
        op = 3'd1; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd9;
        @(negedge clk);
        op = 3'd4; a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = 32'd1000; b = 32'd1000;
        wait_done("busy_ignore", n);
        check("busy_ignore_hi", hi, 32'd0);
        check("busy_ignore_lo", lo, 32'd12);
        @(negedge clk);

        // reset in the middle of a divide
        op = 3'd3; a = 32'd50; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);

        run_op("divu_restart", 3'd3, 32'd50, 32'd7);
        check("divu_restart_lo", lo, 32'd7);
        check("divu_restart_hi", hi, 32'd1);
        // issued in the done cycle of the previous op
        run_op("b2b_multu", 3'd1, 32'd6, 32'd7);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd42);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-003 SHALL have port a, input, 32 bits: rs operand (multiplicand / dividend / MTHI-MTLO data).
REQ-004 SHALL have port b, input, 32 bits: rt operand (multiplier / divisor).
REQ-005 SHALL have port op, input, 3 bits, encoded as follows.
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
- 110 and 111 are no-ops.
REQ-006 SHALL have port start, input, 1 bit: request; a, b and op are sampled on the same edge.
REQ-007 SHALL have port hi, output, 32 bits: HI register, always visible (MFHI source).
REQ-008 SHALL have port lo, output, 32 bits: LO register, always visible (MFLO source).
REQ-009 SHALL have port busy, output, 1 bit: high while an iterative operation is in progress (pipeline stall).
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO take a new mul/div result.

Function
REQ-011 SHALL implement three states: IDLE, CALC, FINISH. busy SHALL equal (state != IDLE).
REQ-012 In IDLE, start=1 with op 000-011 SHALL do all of the following on edge E0:
- latch |a| and |b| for signed ops, or raw a and b for unsigned ops;
- latch the result-sign flags;
- clear the 6-bit iteration counter;
- enter CALC.
REQ-013 CALC SHALL perform exactly one iteration per cycle for 32 cycles (counter 0..31), then enter FINISH.
- Multiply: shift-add, 64-bit product.
- Divide: restoring, 32-bit quotient and 32-bit remainder.
REQ-014 FINISH SHALL last one cycle. On its closing edge E33 it SHALL:
- apply the sign correction;
- write hi and lo;
- set done=1;
- return to IDLE.
done SHALL be high for exactly the cycle after E33. busy SHALL be high for exactly the 33 cycles E0..E33.
REQ-015 Multiply SHALL write hi = product[63:32] and lo = product[31:0].
- MULT: two's-complement product.
- MULTU: unsigned product.
REQ-016 Divide SHALL write lo = quotient and hi = remainder.
- DIV: quotient truncated toward zero; remainder takes the sign of the dividend.
- DIVU: unsigned quotient and remainder.
REQ-017 Divide by zero (b==0, DIV or DIVU) SHALL still take 33 cycles and SHALL write hi=a (as sampled) and lo=32'hFFFFFFFF.
REQ-018 DIV 32'h80000000 / 32'hFFFFFFFF SHALL write lo=32'h80000000 and hi=0, with no exception or flag.
REQ-019 In IDLE, start=1 with op 100 (MTHI) SHALL write hi=a on the same edge; 101 (MTLO) SHALL write lo=a.
- No busy and no done.
- The other register is unchanged.
REQ-020 In IDLE, start=1 with op 110 or 111 SHALL have no effect.
REQ-021 start SHALL be ignored while busy=1, for every op including MTHI/MTLO. Operand and op changes during CALC SHALL NOT affect the result.
REQ-022 start=1 in the cycle done=1 (state IDLE) SHALL be accepted normally, allowing back-to-back operations every 34 cycles.
REQ-023 hi and lo SHALL hold their values at all times except on the writes in REQ-014 and REQ-019.
REQ-024 Width rules:
- multiply accumulator 64 bits;
- divide partial remainder 33 bits;
- sign correction by two's-complement negation at full width;
- counter width 6 bits with no wrap beyond 32 iterations.

Reset
REQ-025 An edge with rst_n=0 SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, regardless of start.
REQ-026 Reset during CALC or FINISH SHALL abort the operation with no partial HI/LO write. The first operation after rst_n returns high SHALL behave as from power-up.

Verification
REQ-027 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> 33 cycles busy, then done pulse; hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-028 MULT a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-029 DIVU a=100, b=0 -> hi=32'h00000064, lo=32'hFFFFFFFF after 33 cycles. DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-030 MTHI a=32'h12345678 in IDLE -> hi=32'h12345678 on the next edge; lo unchanged; busy and done stay 0. MTLO during busy -> lo unchanged.
REQ-031 Start DIVU 50/7 and pulse rst_n=0 at counter=10 -> next edge busy=0, hi=0, lo=0, no done. A restarted DIVU 50/7 -> lo=7, hi=1.
REQ-032 Back-to-back: start MULTU 6*7 in the done cycle of a previous op -> accepted; hi=0, lo=42 after 33 more cycles.
